io_input_ctrl: RTL and testbench
================================

# io_input_ctrl

Memory-mapped input peripheral that drives the CPU's view of the board switches and buttons. It synchronizes and debounces raw `i_io_sw`/`i_io_btn`, exposes stable values and event status through a small register window on the load/store I/O path, and raises a level interrupt to the interrupt handler on switch change or button press. It is the driving end of the switch/button interface that pipeline benches stimulate.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronized input must differ from its stable value before the stable value updates. Legal range is 2..65535.
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_io_sw`  in  32: raw switches, asynchronous to `i_clk`.
- `i_io_btn`  in  4: raw buttons, asynchronous, active-high.
- `i_rd_en`  in  1: register read strobe, one cycle.
- `i_wr_en`  in  1: register write strobe, one cycle.
- `i_addr`  in  2: word index. 0 = SW, 1 = BTN, 2 = PEND, 3 = IEN.
- `i_wdata`  in  32: write data.
- `o_rdata`  out  32: read data, registered.
- `o_rdata_vld`  out  1: high for exactly one cycle, the cycle after `i_rd_en`.
- `o_irq`  out  1: level interrupt, registered.

## Operation
**Synchronizers**
- Each raw bit passes through a 2-flop synchronizer.

**Switch debounce (group)**
- One shared counter.
- Counter increments while `sync_sw != stable_sw`. It clears to 0 when they are equal.
- When the counter would reach `DEBOUNCE_CYCLES`: `stable_sw <= sync_sw`, counter clears, `pend[0]` sets.

**Button debounce (per button)**
- Same rule as switches, with one independent counter per button.
- `pend[i+1]` sets only on a 0→1 transition of `stable_btn[i]`. Releases set nothing.

**Registers**
- SW: reads `stable_sw`. Writes ignored.
- BTN: reads `{28'b0, stable_btn}`. Writes ignored.
- PEND: reads `{27'b0, pend[4:0]}`. Write-1-to-clear using `i_wdata[4:0]`.
- IEN: reads and writes `ien[4:0]`. Bits 31:5 read 0.

**Interrupt**
- `o_irq <= |(pend & ien)`, evaluated on current register values each cycle.

**Simultaneous events**
- Set beats W1C clear on the same bit in the same cycle; the bit stays 1.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- A read of PEND in the cycle a bit sets returns the old value.
- A stable update concurrent with a read of SW/BTN returns the old value.

**Other boundary rules**
- `o_rdata` holds its last value when no read occurs.
- Writing IEN with a pending bit already set raises `o_irq` on the following edge.
- Nonzero switches at reset release debounce normally and set `pend[0]`. IEN=0 after reset, so no interrupt results.

## Timing
**Reset values**
- `o_rdata` = 0, `o_rdata_vld` = 0, `o_irq` = 0.
- Synchronizers, stable values, counters, `pend` and `ien` all 0.
- Reset mid-debounce discards the count. Reset mid-read suppresses `o_rdata_vld`.

**Latency**
- A raw change meeting setup before edge k reaches sync output at edge k+1.
- The stable value and pend bit update at edge k+1+`DEBOUNCE_CYCLES`.
- `o_irq` asserts at edge k+2+`DEBOUNCE_CYCLES`.
- A W1C clear takes effect at the write edge; `o_irq` drops one edge later.
- Read latency is 1 cycle. Back-to-back reads are allowed every cycle.

**Glitch rejection**
- A pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no stable change and no pend.
- A bounce that returns to the stable value restarts the count from 0.

**Counter width**
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. Counters saturate; they cannot wrap.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. Reset, then set `i_io_sw`=100 held → SW reads 100 at 6 cycles after change; `pend`=0x01; `o_irq` stays 0 (IEN=0).
2. Write IEN=0x1F, then pulse `i_io_btn[2]` high for 3 cycles → no pend. Hold it high 10 cycles → `pend`=0x08 at edge k+5, `o_irq`=1 at k+6. Release sets nothing.
3. Write PEND=0x08 → `pend`=0, `o_irq` falls the next edge. Repeat the write in the same cycle a new press of btn[2] debounces → `pend[3]` remains 1.
4. Toggle `i_io_sw` bit 0 every 2 cycles for 20 cycles, then hold 0x5 → exactly one stable update to 0x5 and one `pend[0]` set.
5. Read addr 2 in the cycle `pend[1]` sets → returns 0. Read next cycle → returns 0x02. `o_rdata_vld` high exactly one cycle per read.
6. Assert `i_rst_n`=0 mid-debounce with btn held and `pend`/`ien` nonzero → all outputs 0 asynchronously. After release, debounce restarts from 0 and completes `DEBOUNCE_CYCLES`+1 cycles after sync.

Source files
------------

// File: rtl/io_input_ctrl_if.sv
// Load/store I/O register bus between the CPU and the input peripheral.
interface io_input_ctrl_if;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_rdata_vld;

    modport master (
        output i_rd_en, i_wr_en, i_addr, i_wdata,
        input  o_rdata, o_rdata_vld
    );

    modport slave (
        input  i_rd_en, i_wr_en, i_addr, i_wdata,
        output o_rdata, o_rdata_vld
    );
endinterface

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronizes and debounces board switches/buttons, exposes
// them through a four-word register window and raises a level interrupt.
module io_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [31:0]    i_io_sw,
    input  logic [3:0]     i_io_btn,
    io_input_ctrl_if.slave bus,
    output logic           o_irq
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_BTN  = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_IEN  = 2'd3;

    logic [31:0]      sw_meta, sw_sync, stable_sw;
    logic [3:0]       btn_meta, btn_sync, stable_btn;
    logic [CNT_W-1:0] sw_cnt, sw_cnt_nxt;
    logic [CNT_W-1:0] btn_cnt     [4];
    logic [CNT_W-1:0] btn_cnt_nxt [4];
    logic             sw_upd;
    logic [3:0]       btn_upd;
    logic [4:0]       pend, ien, pend_set, pend_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata_hi;

    // upper write-data bits have no register behind them
    assign unused_wdata_hi = ^bus.i_wdata[31:5];

    // two-flop synchronizers on every raw input bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    // debounce counters: count while synced differs from stable; the cycle
    // that would reach DEBOUNCE_CYCLES commits instead, so counters never wrap
    always_comb begin
        sw_upd     = 1'b0;
        sw_cnt_nxt = '0;
        if (sw_sync != stable_sw) begin
            if (sw_cnt >= CNT_LAST) sw_upd = 1'b1;
            else                    sw_cnt_nxt = sw_cnt + CNT_W'(1);
        end
        btn_upd = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            btn_cnt_nxt[i] = '0;
            if (btn_sync[i] != stable_btn[i]) begin
                if (btn_cnt[i] >= CNT_LAST) btn_upd[i] = 1'b1;
                else                        btn_cnt_nxt[i] = btn_cnt[i] + CNT_W'(1);
            end
        end
    end

    // debounce state: counters and stable values
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_cnt     <= '0;
            stable_sw  <= '0;
            stable_btn <= '0;
            for (int unsigned i = 0; i < 4; i++) btn_cnt[i] <= '0;
        end else begin
            sw_cnt <= sw_cnt_nxt;
            if (sw_upd) stable_sw <= sw_sync;
            for (int unsigned i = 0; i < 4; i++) begin
                btn_cnt[i] <= btn_cnt_nxt[i];
                if (btn_upd[i]) stable_btn[i] <= btn_sync[i];
            end
        end
    end

    // pend set/clear terms and read-data selection from pre-edge values
    always_comb begin
        pend_set = {btn_upd & btn_sync, sw_upd};
        pend_clr = (bus.i_wr_en && bus.i_addr == ADDR_PEND) ? bus.i_wdata[4:0] : '0;
        case (bus.i_addr)
            ADDR_SW:   rd_mux = stable_sw;
            ADDR_BTN:  rd_mux = {28'd0, stable_btn};
            ADDR_PEND: rd_mux = {27'd0, pend};
            default:   rd_mux = {27'd0, ien};
        endcase
    end

    // pend (write-1-to-clear, set wins) and interrupt enable registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend <= '0;
            ien  <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
            if (bus.i_wr_en && bus.i_addr == ADDR_IEN) ien <= bus.i_wdata[4:0];
        end
    end

    // registered read port; data holds between reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_rdata     <= '0;
            bus.o_rdata_vld <= 1'b0;
        end else begin
            bus.o_rdata_vld <= bus.i_rd_en;
            if (bus.i_rd_en) bus.o_rdata <= rd_mux;
        end
    end

    // level interrupt from current pend and enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_irq <= 1'b0;
        else          o_irq <= |(pend & ien);
    end
endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios, a register-access vector
// table and randomized traffic against a history-based reference model.
module tb_io_input_ctrl;
    localparam int unsigned DB = 4;

    logic        i_clk    = 1'b0;
    logic        i_rst_n  = 1'b0;
    logic [31:0] i_io_sw  = '0;
    logic [3:0]  i_io_btn = '0;
    logic        o_irq;

    io_input_ctrl_if bus();

    io_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_io_sw  (i_io_sw),
        .i_io_btn (i_io_btn),
        .bus      (bus),
        .o_irq    (o_irq)
    );

    always #5 i_clk = ~i_clk;

    // reference model: a raw input becomes visible to debounce two edges
    // after sampling; a stable value takes the newest sample once the last
    // DB samples all differ from it
    logic [35:0] raw_q[$];
    logic [35:0] syn_q[$];
    logic [31:0] m_sw;
    logic [3:0]  m_btn;
    logic [4:0]  m_pend, m_ien;
    logic [31:0] m_rdata;
    logic        m_vld, m_irq;

    function automatic void model_reset();
        raw_q = '{36'd0, 36'd0};
        syn_q = {};
        for (int j = 0; j < int'(DB); j++) syn_q.push_back(36'd0);
        m_sw = '0; m_btn = '0; m_pend = '0; m_ien = '0;
        m_rdata = '0; m_vld = 1'b0; m_irq = 1'b0;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin : model_step
        logic [35:0] s;
        logic [4:0]  set, clr;
        bit          all_diff;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            m_vld = bus.i_rd_en;
            if (bus.i_rd_en) begin
                case (bus.i_addr)
                    2'd0:    m_rdata = m_sw;
                    2'd1:    m_rdata = {28'd0, m_btn};
                    2'd2:    m_rdata = {27'd0, m_pend};
                    default: m_rdata = {27'd0, m_ien};
                endcase
            end
            m_irq = |(m_pend & m_ien);
            s = raw_q[1];
            raw_q.push_front({i_io_btn, i_io_sw});
            void'(raw_q.pop_back());
            syn_q.push_front(s);
            void'(syn_q.pop_back());
            set = '0;
            all_diff = 1'b1;
            foreach (syn_q[j]) if (syn_q[j][31:0] == m_sw) all_diff = 1'b0;
            if (all_diff) begin
                m_sw = s[31:0];
                set[0] = 1'b1;
            end
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                foreach (syn_q[j]) if (syn_q[j][32+b] == m_btn[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_btn[b] = s[32+b];
                    if (s[32+b]) set[b+1] = 1'b1;
                end
            end
            clr = (bus.i_wr_en && bus.i_addr == 2'd2) ? bus.i_wdata[4:0] : 5'd0;
            if (bus.i_wr_en && bus.i_addr == 2'd3) m_ien = bus.i_wdata[4:0];
            m_pend = (m_pend & ~clr) | set;
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // advance to the next falling edge and compare outputs with the model
    task automatic tick();
        @(negedge i_clk);
        check("sb_rdata", bus.o_rdata, m_rdata);
        check("sb_vld", 32'(bus.o_rdata_vld), 32'(m_vld));
        check("sb_irq", 32'(o_irq), 32'(m_irq));
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.i_rd_en = 1'b1;
        bus.i_addr  = a;
        tick();
        bus.i_rd_en = 1'b0;
        check("rd_vld", 32'(bus.o_rdata_vld), 32'd1);
        d = bus.o_rdata;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
        bus.i_wr_en = 1'b1;
        bus.i_addr  = a;
        bus.i_wdata = v;
        tick();
        bus.i_wr_en = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_vld;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [16];

    initial begin : main
        logic [31:0] d;
        int          hold;

        // state entering the table: SW=5, BTN=9, PEND=0x13, IEN=0
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h5,  1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h9,  1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h13, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0,  1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd3, 32'hFFFFFFE5, 32'h0,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h5,  1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 2'd3, 32'h0A,       32'h5,  1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0A, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 32'h1234,     32'h0A, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h5,  1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 32'hF,        32'h5,  1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h9,  1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'd2, 32'h03,       32'h13, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h10, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 32'hFF,       32'h10, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0,  1'b1, 1'b0};

        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_addr  = 2'd0;
        bus.i_wdata = '0;

        repeat (3) tick();
        check("rst_rdata", bus.o_rdata, 32'd0);
        check("rst_vld", 32'(bus.o_rdata_vld), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        #2 i_rst_n = 1'b1;

        // switch debounce latency and read concurrent with the update
        i_io_sw = 32'd100;
        repeat (5) tick();
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 2'd0;
        tick();
        check("s1_sw_old", bus.o_rdata, 32'd0);
        tick();
        check("s1_sw_new", bus.o_rdata, 32'd100);
        bus.i_rd_en = 1'b0;
        rd_reg(2'd2, d);
        check("s1_pend", d, 32'h01);
        check("s1_irq", 32'(o_irq), 32'd0);

        // button glitch rejection, press latency and release
        wr_reg(2'd2, 32'h1F);
        wr_reg(2'd3, 32'h1F);
        i_io_btn = 4'b0100;
        repeat (3) tick();
        i_io_btn = 4'b0000;
        repeat (8) tick();
        rd_reg(2'd2, d);
        check("s2_glitch_pend", d, 32'h0);
        i_io_btn = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) check("s2_irq_before", 32'(o_irq), 32'd0);
            if (i == 7) check("s2_irq_after", 32'(o_irq), 32'd1);
        end
        i_io_btn = 4'b0000;
        repeat (10) tick();
        rd_reg(2'd2, d);
        check("s2_pend", d, 32'h08);

        // W1C timing, then set beating a simultaneous clear
        bus.i_wr_en = 1'b1;
        bus.i_addr  = 2'd2;
        bus.i_wdata = 32'h08;
        tick();
        bus.i_wr_en = 1'b0;
        check("s3_irq_hold", 32'(o_irq), 32'd1);
        tick();
        check("s3_irq_drop", 32'(o_irq), 32'd0);
        i_io_btn = 4'b0100;
        repeat (5) tick();
        wr_reg(2'd2, 32'h08);
        rd_reg(2'd2, d);
        check("s3_set_wins", d, 32'h08);
        i_io_btn = 4'b0000;
        repeat (8) tick();
        wr_reg(2'd2, 32'h1F);

        // fast bounce on sw[0] never settles; then a held value settles once
        for (int c = 0; c < 10; c++) begin
            i_io_sw = i_io_sw ^ 32'd1;
            tick();
            tick();
        end
        rd_reg(2'd2, d);
        check("s4_bounce_pend", d, 32'h0);
        i_io_sw = 32'h5;
        repeat (8) tick();
        rd_reg(2'd0, d);
        check("s4_sw", d, 32'h5);
        rd_reg(2'd2, d);
        check("s4_pend", d, 32'h01);

        // PEND read in the setting cycle returns the old value
        wr_reg(2'd2, 32'h1F);
        i_io_btn = 4'b0001;
        repeat (5) tick();
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 2'd2;
        tick();
        check("s5_rd_old", bus.o_rdata, 32'h0);
        check("s5_vld0", 32'(bus.o_rdata_vld), 32'd1);
        tick();
        check("s5_rd_new", bus.o_rdata, 32'h02);
        check("s5_vld1", 32'(bus.o_rdata_vld), 32'd1);
        bus.i_rd_en = 1'b0;
        tick();
        check("s5_vld_off", 32'(bus.o_rdata_vld), 32'd0);
        check("s5_rdata_hold", bus.o_rdata, 32'h02);

        // async reset mid-debounce and mid-read
        i_io_btn = 4'b1001;
        repeat (3) tick();
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 2'd2;
        #2 i_rst_n = 1'b0;
        #1;
        check("s6_rst_rdata", bus.o_rdata, 32'd0);
        check("s6_rst_vld", 32'(bus.o_rdata_vld), 32'd0);
        check("s6_rst_irq", 32'(o_irq), 32'd0);
        tick();
        bus.i_rd_en = 1'b0;
        #2 i_rst_n = 1'b1;
        repeat (5) tick();
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 2'd1;
        tick();
        check("s6_btn_old", bus.o_rdata, 32'h0);
        tick();
        check("s6_btn_new", bus.o_rdata, 32'h9);
        bus.i_rd_en = 1'b0;
        rd_reg(2'd2, d);
        check("s6_pend", d, 32'h13);
        rd_reg(2'd3, d);
        check("s6_ien", d, 32'h0);
        check("s6_irq", 32'(o_irq), 32'd0);

        // register access vectors
        for (int i = 0; i < 16; i++) begin
            bus.i_rd_en = tbl[i].rd;
            bus.i_wr_en = tbl[i].wr;
            bus.i_addr  = tbl[i].addr;
            bus.i_wdata = tbl[i].wdata;
            tick();
            check($sformatf("tbl%0d_rdata", i), bus.o_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_vld", i), 32'(bus.o_rdata_vld), 32'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_irq", i), 32'(o_irq), 32'(tbl[i].exp_irq));
        end
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;

        // randomized traffic checked against the model every cycle
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                if ($urandom_range(1, 0) == 1) i_io_sw = i_io_sw ^ (32'd1 << $urandom_range(31, 0));
                else                           i_io_sw = $urandom;
                hold = int'($urandom_range(9, 1));
            end
            hold--;
            if ($urandom_range(5, 0) == 0) i_io_btn = i_io_btn ^ (4'd1 << $urandom_range(3, 0));
            bus.i_rd_en = $urandom_range(1, 0) == 1;
            bus.i_wr_en = $urandom_range(3, 0) == 0;
            bus.i_addr  = 2'($urandom_range(3, 0));
            bus.i_wdata = $urandom;
            tick();
        end
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
